// File: rtl/image_reader_if.sv
// AXI4 read-address/read-data channels plus the 8-bit pixel stream of the image reader.
// The master modport is the reader side; the slave modport is the memory/sink side.
interface image_reader_if;
  logic        m00_axi_arvalid;
  logic        m00_axi_arready;
  logic [31:0] m00_axi_araddr;
  logic [7:0]  m00_axi_arlen;
  logic [2:0]  m00_axi_arsize;
  logic [1:0]  m00_axi_arburst;
  logic        m00_axi_rvalid;
  logic        m00_axi_rready;
  logic [31:0] m00_axi_rdata;
  logic [1:0]  m00_axi_rresp;
  logic        m00_axi_rlast;
  logic [7:0]  o_img_data;
  logic        o_img_data_valid;
  logic        i_img_data_ready;

  modport master (
    output m00_axi_arvalid, m00_axi_araddr, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst,
    output m00_axi_rready, o_img_data, o_img_data_valid,
    input  m00_axi_arready, m00_axi_rvalid, m00_axi_rdata, m00_axi_rresp, m00_axi_rlast,
    input  i_img_data_ready
  );

  modport slave (
    input  m00_axi_arvalid, m00_axi_araddr, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst,
    input  m00_axi_rready, o_img_data, o_img_data_valid,
    output m00_axi_arready, m00_axi_rvalid, m00_axi_rdata, m00_axi_rresp, m00_axi_rlast,
    output i_img_data_ready
  );
endinterface

// File: rtl/image_reader.sv
// AXI4 read master: fetches one packed 8-bit frame in INCR bursts, buffers words in a FIFO
// and unpacks them into a byte stream (pixel n in byte lane n%4, low byte first).
module image_reader #(
  parameter int imageSize = 640*480,
  parameter int burstSize = 16,
  parameter int fifoDepth = 64
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic [31:0]   i_ddrStartAddr,
  output logic          o_rd_done,
  output logic          o_rd_err,
  image_reader_if.master io_bus
);

  localparam int WORDS  = imageSize / 4;
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int PCNT_W = $clog2(imageSize + 1);
  localparam int AW     = $clog2(fifoDepth);
  localparam int FCNT_W = AW + 1;
  localparam int LEN_W  = 9;

  typedef enum logic [1:0] {WAIT_START, REQ, DATA, DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_start_d;
  logic [31:0]         r_addr;
  logic [WCNT_W-1:0]   r_words_left;
  logic [PCNT_W-1:0]   r_pix_left;
  logic                r_arvalid;
  logic [31:0]         r_araddr;
  logic [7:0]          r_arlen;
  logic                r_rd_done;
  logic                r_rd_err;

  logic [31:0]         r_mem [fifoDepth];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [FCNT_W-1:0]   r_count;

  logic [31:0]         r_word;
  logic [2:0]          r_bcnt;

  logic                w_start;
  logic                w_ar_hs;
  logic                w_rready;
  logic                w_push;
  logic                w_pop;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic [31:0]         w_fifo_rdata;
  logic [FCNT_W-1:0]   w_free;
  logic [LEN_W-1:0]    w_len;
  logic                w_space_ok;
  logic                w_pix_valid;
  logic                w_pix_hs;

  assign w_start      = i_start & ~r_start_d;
  assign w_ar_hs      = r_arvalid & io_bus.m00_axi_arready;
  assign w_rready     = (r_state == DATA);
  assign w_push       = io_bus.m00_axi_rvalid & w_rready;
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == FCNT_W'(fifoDepth));
  assign w_fifo_rdata = r_mem[r_rd_ptr];
  assign w_free       = FCNT_W'(fifoDepth) - r_count;
  assign w_pix_valid  = (r_bcnt != 3'd0);
  assign w_pix_hs     = w_pix_valid & io_bus.i_img_data_ready;
  // Refill the unpacker while its last byte leaves so the stream has no bubble.
  assign w_pop        = ~w_fifo_empty &
                        ((r_bcnt == 3'd0) | ((r_bcnt == 3'd1) & io_bus.i_img_data_ready));

  always_comb begin
    w_len = LEN_W'(burstSize);
    if (32'(r_words_left) < 32'(burstSize)) w_len = LEN_W'(r_words_left);
  end

  assign w_space_ok = (32'(w_free) >= 32'(w_len));

  assign io_bus.m00_axi_arvalid  = r_arvalid;
  assign io_bus.m00_axi_araddr   = r_araddr;
  assign io_bus.m00_axi_arlen    = r_arlen;
  assign io_bus.m00_axi_arsize   = 3'b010;
  assign io_bus.m00_axi_arburst  = 2'b01;
  assign io_bus.m00_axi_rready   = w_rready;
  assign io_bus.o_img_data       = r_word[7:0];
  assign io_bus.o_img_data_valid = w_pix_valid;
  assign o_rd_done               = r_rd_done;
  assign o_rd_err                = r_rd_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_START: if (w_start) w_state_nxt = REQ;
      REQ:        if (w_ar_hs) w_state_nxt = DATA;
      DATA: begin
        if (w_push && io_bus.m00_axi_rlast)
          w_state_nxt = (r_words_left != '0) ? REQ : DRAIN;
      end
      DRAIN:      if (r_pix_left == '0) w_state_nxt = WAIT_START;
      default:    w_state_nxt = WAIT_START;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= WAIT_START;
      r_start_d    <= 1'b0;
      r_addr       <= '0;
      r_words_left <= '0;
      r_pix_left   <= '0;
      r_arvalid    <= 1'b0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_rd_done    <= 1'b0;
      r_rd_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= i_start;
      r_rd_done <= (r_state == DRAIN) && (r_pix_left == '0);

      if (r_state == WAIT_START && w_start) begin
        r_addr       <= i_ddrStartAddr;
        r_words_left <= WCNT_W'(WORDS);
        r_pix_left   <= PCNT_W'(imageSize);
        r_rd_err     <= 1'b0;
      end else begin
        if (w_push && (io_bus.m00_axi_rresp != 2'b00)) r_rd_err <= 1'b1;
        if (w_pix_hs) r_pix_left <= r_pix_left - PCNT_W'(1);
      end

      // A request is only raised once the FIFO can absorb the whole burst, so
      // the R channel never needs to be back-pressured.
      if (r_state == REQ) begin
        if (w_ar_hs) begin
          r_arvalid    <= 1'b0;
          r_addr       <= r_addr + {21'd0, w_len, 2'b00};
          r_words_left <= r_words_left - WCNT_W'(w_len);
        end else if (!r_arvalid && w_space_ok) begin
          r_arvalid <= 1'b1;
          r_araddr  <= r_addr;
          r_arlen   <= 8'(w_len - LEN_W'(1));
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= io_bus.m00_axi_rdata;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FCNT_W'(1);
        2'b01:   r_count <= r_count - FCNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word <= '0;
      r_bcnt <= 3'd0;
    end else if (w_pop) begin
      r_word <= w_fifo_rdata;
      r_bcnt <= 3'd4;
    end else if (w_pix_hs) begin
      r_word <= {8'd0, r_word[31:8]};
      r_bcnt <= r_bcnt - 3'd1;
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(w_push && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_image_reader.sv
// Randomized bench for image_reader: AXI read-slave model, random pixel sink and a
// frame-level reference (expected pixels and burst list) derived from the memory image.
module tb_image_reader;
  localparam int IMG    = 136;
  localparam int BURST  = 16;
  localparam int DEPTH  = 64;
  localparam int WORDS  = IMG / 4;
  localparam int NBURST = (WORDS + BURST - 1) / BURST;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic        done, err;

  image_reader_if bus();

  image_reader #(.imageSize(IMG), .burstSize(BURST), .fifoDepth(DEPTH)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_ddrStartAddr(base_addr),
    .o_rd_done(done), .o_rd_err(err), .io_bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit [31:0]   mem [bit [31:0]];
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];
  logic [7:0]  got[$];
  logic [7:0]  expq[$];

  int ar_delay = 0;
  bit gaps = 0;
  bit rand_ready = 0;
  int err_beat = -1;
  int done_cnt = 0, stall_err = 0, ar_err = 0, beat_cnt = 0;

  bit          p_arvalid, p_arready, p_rvalid, p_rready, p_valid, p_ready;
  logic [31:0] p_araddr;
  logic [7:0]  p_arlen, p_data;
  bit          busy;
  int          beats_left, ar_wait;
  logic [31:0] raddr;

  // AXI read slave: decisions at negedge reflect what the DUT sees at the next posedge.
  initial begin
    bus.m00_axi_arready = 1'b0; bus.m00_axi_rvalid = 1'b0; bus.m00_axi_rdata = '0;
    bus.m00_axi_rresp = 2'b00;  bus.m00_axi_rlast = 1'b0;
    busy = 0; ar_wait = 0; beats_left = 0; raddr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.m00_axi_arready = 1'b0; bus.m00_axi_rvalid = 1'b0; bus.m00_axi_rlast = 1'b0;
        busy = 0; ar_wait = 0;
        p_arvalid = 0; p_arready = 0; p_rvalid = 0; p_rready = 0;
      end else begin
        if (p_arvalid && p_arready) begin
          ar_addr_q.push_back(p_araddr);
          ar_len_q.push_back(p_arlen);
          raddr = p_araddr; beats_left = int'(p_arlen) + 1; busy = 1; ar_wait = 0;
        end else if (p_arvalid && (bus.m00_axi_arvalid !== 1'b1 ||
                     bus.m00_axi_araddr !== p_araddr || bus.m00_axi_arlen !== p_arlen)) begin
          ar_err++;
        end
        if (p_rvalid && p_rready) begin
          raddr = raddr + 32'd4; beats_left--; beat_cnt++;
          if (beats_left == 0) busy = 0;
        end
        if (bus.m00_axi_arvalid === 1'b1) begin
          if (ar_wait >= ar_delay) bus.m00_axi_arready = 1'b1;
          else begin bus.m00_axi_arready = 1'b0; ar_wait++; end
        end else begin
          bus.m00_axi_arready = 1'b0; ar_wait = 0;
        end
        if (!(p_rvalid && !p_rready)) begin
          if (busy) begin
            bus.m00_axi_rvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.m00_axi_rdata  = mem.exists(raddr) ? mem[raddr] : 32'hDEADBEEF;
            bus.m00_axi_rlast  = (beats_left == 1);
            bus.m00_axi_rresp  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
          end else begin
            bus.m00_axi_rvalid = 1'b0; bus.m00_axi_rlast = 1'b0; bus.m00_axi_rresp = 2'b00;
          end
        end
        p_arvalid = bus.m00_axi_arvalid; p_arready = bus.m00_axi_arready;
        p_araddr  = bus.m00_axi_araddr;  p_arlen   = bus.m00_axi_arlen;
        p_rvalid  = bus.m00_axi_rvalid;  p_rready  = bus.m00_axi_rready;
      end
    end
  end

  // Pixel sink: collects accepted pixels, watches stall stability and done pulses.
  initial begin
    bus.i_img_data_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_valid = 0; p_ready = 0; bus.i_img_data_ready = 1'b0;
      end else begin
        if (p_valid && p_ready) got.push_back(p_data);
        else if (p_valid && (bus.o_img_data_valid !== 1'b1 || bus.o_img_data !== p_data))
          stall_err++;
        if (done === 1'b1) done_cnt++;
        bus.i_img_data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        p_valid = bus.o_img_data_valid; p_ready = bus.i_img_data_ready; p_data = bus.o_img_data;
      end
    end
  end

  function automatic bit pixels_ok();
    if (got.size() != expq.size()) return 0;
    foreach (expq[i]) if (got[i] !== expq[i]) return 0;
    return 1;
  endfunction

  function automatic bit ars_ok(input logic [31:0] base);
    int rem;
    if (ar_addr_q.size() != NBURST) return 0;
    for (int k = 0; k < NBURST; k++) begin
      rem = WORDS - k * BURST;
      if (ar_addr_q[k] !== base + 32'(k * BURST * 4)) return 0;
      if (int'(ar_len_q[k]) != ((rem < BURST) ? rem : BURST) - 1) return 0;
    end
    return 1;
  endfunction

  task automatic do_frame(input logic [31:0] base, input bit special, output bit timed_out);
    logic [31:0] wd;
    for (int w = 0; w < WORDS; w++) mem[base + 32'(4 * w)] = $urandom;
    if (special) mem[base] = 32'h44332211;
    expq.delete();
    for (int n = 0; n < IMG; n++) begin
      wd = mem[base + 32'(4 * (n / 4))];
      expq.push_back(wd[8 * (n % 4) +: 8]);
    end
    got.delete(); ar_addr_q.delete(); ar_len_q.delete();
    done_cnt = 0; stall_err = 0; ar_err = 0; beat_cnt = 0;
    @(negedge clk); base_addr = base; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    timed_out = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done_cnt > 0) begin timed_out = 0; break; end
    end
    repeat (6) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_base();
    return {4'h2, 28'($urandom)} & 32'hFFFF_FFC0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.m00_axi_arvalid !== 1'b0) $display("FAIL reset_arvalid got %0h exp 0", bus.m00_axi_arvalid); else n_pass++;
    n_checks++; if (bus.m00_axi_rready !== 1'b0) $display("FAIL reset_rready got %0h exp 0", bus.m00_axi_rready); else n_pass++;
    n_checks++; if (bus.o_img_data_valid !== 1'b0) $display("FAIL reset_valid got %0h exp 0", bus.o_img_data_valid); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %0h exp 0", done); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %0h exp 0", err); else n_pass++;
    n_checks++; if (bus.m00_axi_araddr !== 32'd0) $display("FAIL reset_araddr got %0h exp 0", bus.m00_axi_araddr); else n_pass++;
    n_checks++; if (bus.m00_axi_arlen !== 8'd0) $display("FAIL reset_arlen got %0h exp 0", bus.m00_axi_arlen); else n_pass++;
    n_checks++; if (bus.o_img_data !== 8'd0) $display("FAIL reset_data got %0h exp 0", bus.o_img_data); else n_pass++;
    n_checks++; if (bus.m00_axi_arsize !== 3'b010) $display("FAIL arsize got %0h exp 2", bus.m00_axi_arsize); else n_pass++;
    n_checks++; if (bus.m00_axi_arburst !== 2'b01) $display("FAIL arburst got %0h exp 1", bus.m00_axi_arburst); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    do_frame(32'h1000_0000, 1'b0, to);
    n_checks++; if (to) $display("FAIL basic_timeout got no done exp done"); else n_pass++;
    n_checks++; if (!pixels_ok()) $display("FAIL basic_pixels got %0d pixels exp %0d in order", got.size(), IMG); else n_pass++;
    n_checks++; if (!ars_ok(32'h1000_0000)) $display("FAIL basic_ars got %0d bursts exp %0d", ar_addr_q.size(), NBURST); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL basic_done got %0d pulses exp 1", done_cnt); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL basic_err got %0h exp 0", err); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit to;
    logic [31:0] first4;
    logic [31:0] b;
    b = rand_base();
    rand_ready = 1; gaps = 1;
    do_frame(b, 1'b1, to);
    first4 = (got.size() >= 4) ? {got[3], got[2], got[1], got[0]} : 32'hxxxxxxxx;
    n_checks++; if (to) $display("FAIL bp_timeout got no done exp done"); else n_pass++;
    n_checks++; if (first4 !== 32'h44332211) $display("FAIL bp_first_word got %0h exp 44332211", first4); else n_pass++;
    n_checks++; if (!pixels_ok()) $display("FAIL bp_pixels got %0d pixels exp %0d in order", got.size(), IMG); else n_pass++;
    n_checks++; if (stall_err != 0) $display("FAIL bp_stall_stable got %0d violations exp 0", stall_err); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL bp_done got %0d pulses exp 1", done_cnt); else n_pass++;
    rand_ready = 0; gaps = 0;
  endtask

  task automatic test_ar_delay();
    bit to;
    logic [31:0] b;
    b = rand_base();
    ar_delay = 5;
    do_frame(b, 1'b0, to);
    n_checks++; if (to) $display("FAIL ard_timeout got no done exp done"); else n_pass++;
    n_checks++; if (ar_err != 0) $display("FAIL ard_stable got %0d violations exp 0", ar_err); else n_pass++;
    n_checks++; if (!ars_ok(b)) $display("FAIL ard_ars got %0d bursts exp %0d", ar_addr_q.size(), NBURST); else n_pass++;
    n_checks++; if (!pixels_ok()) $display("FAIL ard_pixels got %0d pixels exp %0d in order", got.size(), IMG); else n_pass++;
    ar_delay = 0;
  endtask

  task automatic test_rresp_err();
    bit to;
    err_beat = 5;
    do_frame(rand_base(), 1'b0, to);
    n_checks++; if (to) $display("FAIL err_timeout got no done exp done"); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL err_set got %0h exp 1", err); else n_pass++;
    n_checks++; if (!pixels_ok()) $display("FAIL err_pixels got %0d pixels exp %0d in order", got.size(), IMG); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky got %0h exp 1", err); else n_pass++;
    err_beat = -1;
    do_frame(rand_base(), 1'b0, to);
    n_checks++; if (to) $display("FAIL err2_timeout got no done exp done"); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL err_cleared got %0h exp 0", err); else n_pass++;
  endtask

  task automatic test_start_ignored();
    bit to;
    logic [31:0] b;
    b = rand_base();
    fork
      do_frame(b, 1'b0, to);
      begin
        repeat (40) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    n_checks++; if (to) $display("FAIL restart_timeout got no done exp done"); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL restart_done got %0d pulses exp 1", done_cnt); else n_pass++;
    n_checks++; if (!ars_ok(b)) $display("FAIL restart_ars got %0d bursts exp %0d", ar_addr_q.size(), NBURST); else n_pass++;
    n_checks++; if (!pixels_ok()) $display("FAIL restart_pixels got %0d pixels exp %0d in order", got.size(), IMG); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bit to;
    bit reached;
    logic [31:0] b;
    beat_cnt = 0;
    @(negedge clk); base_addr = 32'h3000_0000; start = 1'b1;
    reached = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (beat_cnt >= 3) begin reached = 1; break; end
    end
    n_checks++; if (!reached) $display("FAIL rstmid_beats got %0d beats exp >=3", beat_cnt); else n_pass++;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.m00_axi_rready !== 1'b0 || bus.m00_axi_arvalid !== 1'b0) $display("FAIL rstmid_axi got rready=%0h arvalid=%0h exp 0", bus.m00_axi_rready, bus.m00_axi_arvalid); else n_pass++;
    n_checks++; if (bus.o_img_data_valid !== 1'b0 || bus.o_img_data !== 8'd0) $display("FAIL rstmid_pix got valid=%0h data=%0h exp 0", bus.o_img_data_valid, bus.o_img_data); else n_pass++;
    n_checks++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL rstmid_flags got done=%0h err=%0h exp 0", done, err); else n_pass++;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    b = rand_base();
    do_frame(b, 1'b0, to);
    n_checks++; if (to) $display("FAIL rstmid_timeout got no done exp done"); else n_pass++;
    n_checks++; if (!ars_ok(b)) $display("FAIL rstmid_ars got %0d bursts exp %0d", ar_addr_q.size(), NBURST); else n_pass++;
    n_checks++; if (!pixels_ok()) $display("FAIL rstmid_pixels got %0d pixels exp %0d in order", got.size(), IMG); else n_pass++;
    n_checks++; if (done_cnt != 1) $display("FAIL rstmid_done got %0d pulses exp 1", done_cnt); else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ar_delay();
    test_rresp_err();
    test_start_ignored();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
